// File: rtl/ps2_host_tx_if.sv
// PS/2 host transmitter bundle: command byte request, raw line levels, drive-low enables, status.
// Latency: none (plain wires).
// Backpressure: none; the system side must watch Tx_Busy_Out before asking for another start.
interface ps2_host_tx_if;
    logic [7:0] Tx_Data_In;
    logic       Tx_Start_In;
    logic       PS2_CLK_In;
    logic       PS2_DATA_In;
    logic       PS2_Clk_Drive_Low_Out;
    logic       PS2_Data_Drive_Low_Out;
    logic       Tx_Busy_Out;
    logic       Tx_Done_Out;
    logic       Tx_Ack_Error_Out;
    logic       Rx_Inhibit_Out;

    // System side: issues commands and supplies the resolved line levels.
    modport master (
        output Tx_Data_In, Tx_Start_In, PS2_CLK_In, PS2_DATA_In,
        input  PS2_Clk_Drive_Low_Out, PS2_Data_Drive_Low_Out,
        input  Tx_Busy_Out, Tx_Done_Out, Tx_Ack_Error_Out, Rx_Inhibit_Out
    );

    // Transmitter side.
    modport slave (
        input  Tx_Data_In, Tx_Start_In, PS2_CLK_In, PS2_DATA_In,
        output PS2_Clk_Drive_Low_Out, PS2_Data_Drive_Low_Out,
        output Tx_Busy_Out, Tx_Done_Out, Tx_Ack_Error_Out, Rx_Inhibit_Out
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data + odd parity + stop, ACK check.
// Latency: busy one cycle after start; frame timing is set by the device clock; done 3-4 cycles after lines idle.
// Backpressure: starts are dropped while busy; a start in the done cycle is accepted.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2500,
    parameter int unsigned TIMEOUT_CYCLES = 375000
) (
    input logic          Master_Clock_In,
    input logic          Reset_N_In,
    ps2_host_tx_if.slave bus
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t           state;
    logic             clk_s1, clk_s2, clk_prev;
    logic             dat_s1, dat_s2;
    logic             fe;
    logic [INH_W-1:0] inh_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [3:0]       idx;
    logic [9:0]       shift_reg;
    logic             ack_nok;
    logic             clk_low, data_low, busy, done, ack_err;

    // Bring both open-drain lines into the core clock domain; idle level is high.
    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= bus.PS2_CLK_In;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= bus.PS2_DATA_In;
            dat_s2   <= dat_s1;
        end
    end

    assign fe = clk_prev & ~clk_s2;

    // Frame sequencer with registered line drives and status pulses.
    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state     <= S_IDLE;
            inh_cnt   <= '0;
            tmo_cnt   <= '0;
            idx       <= '0;
            shift_reg <= '0;
            ack_nok   <= 1'b0;
            clk_low   <= 1'b0;
            data_low  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            ack_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    clk_low  <= 1'b0;
                    data_low <= 1'b0;
                    busy     <= 1'b0;
                    if (bus.Tx_Start_In) begin
                        // Stop bit on top, odd parity below it, data LSB first.
                        shift_reg <= {1'b1, ~(^bus.Tx_Data_In), bus.Tx_Data_In};
                        inh_cnt   <= '0;
                        clk_low   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        // Request-to-send: data low while clock is still held for one more cycle.
                        data_low <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= S_REQ;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                S_REQ, S_SHIFT, S_ACK: begin
                    if (!fe && tmo_cnt == TMO_LAST) begin
                        // Device went quiet: give the lines back and report failure at once.
                        clk_low  <= 1'b0;
                        data_low <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        ack_err  <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        tmo_cnt <= fe ? '0 : tmo_cnt + 1'b1;
                        case (state)
                            S_REQ: begin
                                clk_low <= 1'b0;
                                idx     <= '0;
                                state   <= S_SHIFT;
                            end
                            S_SHIFT: begin
                                if (fe) begin
                                    data_low <= ~shift_reg[idx];
                                    idx      <= idx + 1'b1;
                                    if (idx == 4'd9) state <= S_ACK;
                                end
                            end
                            default: begin
                                if (fe) begin
                                    ack_nok <= dat_s2;
                                    state   <= S_WAIT_IDLE;
                                end
                            end
                        endcase
                    end
                end
                S_WAIT_IDLE: begin
                    if (clk_s2 && dat_s2) begin
                        done    <= 1'b1;
                        ack_err <= ack_nok;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.PS2_Clk_Drive_Low_Out  = clk_low;
    assign bus.PS2_Data_Drive_Low_Out = data_low;
    assign bus.Tx_Busy_Out            = busy;
    assign bus.Tx_Done_Out            = done;
    assign bus.Tx_Ack_Error_Out       = ack_err;
    assign bus.Rx_Inhibit_Out         = busy;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device-side PS/2 model clocks frames out of the host and checks them.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TMO = 400;
    localparam int H   = 20;   // device clock half period in core cycles

    localparam int M_ACK    = 0;
    localparam int M_NOACK  = 1;
    localparam int M_SILENT = 2;
    localparam int M_RESET  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ps2_host_tx_if bus();

    // Open-drain wired-AND of host and device drivers.
    assign bus.PS2_CLK_In  = ~bus.PS2_Clk_Drive_Low_Out & dev_clk;
    assign bus.PS2_DATA_In = ~bus.PS2_Data_Drive_Low_Out & dev_data;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .Master_Clock_In (clk),
        .Reset_N_In      (rst_n),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [5:0] outs();
        return {bus.PS2_Clk_Drive_Low_Out, bus.PS2_Data_Drive_Low_Out, bus.Tx_Busy_Out,
                bus.Tx_Done_Out, bus.Tx_Ack_Error_Out, bus.Rx_Inhibit_Out};
    endfunction

    // Expected bit stream as seen by the device: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] expected_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            if (d[i]) ones++;
        end
        f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    // Called at a negedge; returns at the negedge of the first cycle after acceptance.
    task automatic issue_start(input logic [7:0] d);
        bus.Tx_Data_In  = d;
        bus.Tx_Start_In = 1'b1;
        tick();
        bus.Tx_Start_In = 1'b0;
        bus.Tx_Data_In  = 8'($urandom);
        check("busy_after_start", 32'(bus.Tx_Busy_Out), 32'd1);
        check("inhibit_after_start", 32'(bus.Rx_Inhibit_Out), 32'd1);
    endtask

    task automatic do_frame(input logic [7:0] d, input int mode, input bit glitch,
                            input bit chain, input logic [7:0] d2);
        int n;
        logic [10:0] got;
        logic [10:0] want;
        want = expected_frame(d);
        got  = '0;

        n = 0;
        while (bus.PS2_Clk_Drive_Low_Out && !bus.PS2_Data_Drive_Low_Out && n < INH + 50) begin
            n++;
            tick();
        end
        check("inhibit_len", 32'(n), 32'(INH));
        check("req_both_low", 32'({bus.PS2_Clk_Drive_Low_Out, bus.PS2_Data_Drive_Low_Out}), 32'b11);
        tick();
        check("req_clk_released", 32'({bus.PS2_Clk_Drive_Low_Out, bus.PS2_Data_Drive_Low_Out}), 32'b01);

        if (mode == M_SILENT) begin
            n = 1;
            while (!bus.Tx_Done_Out && n < TMO + 50) begin
                tick();
                n++;
            end
            check("timeout_len", 32'(n), 32'(TMO));
            check("timeout_outs", 32'(outs()), 32'b000110);
            tick();
            check("timeout_pulse_end", 32'(outs()), 32'b000000);
            return;
        end

        repeat (H) tick();
        got[0] = bus.PS2_DATA_In;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            repeat (H) tick();
            dev_clk = 1'b1;
            repeat (H) tick();
            got[k] = bus.PS2_DATA_In;
            if (glitch && k == 5) begin
                bus.Tx_Data_In  = 8'($urandom);
                bus.Tx_Start_In = 1'b1;
                tick();
                bus.Tx_Start_In = 1'b0;
            end
            if (mode == M_RESET && k == 5) begin
                rst_n = 1'b0;
                #1;
                check("reset_mid_outs", 32'(outs()), 32'b000000);
                tick();
                rst_n = 1'b1;
                repeat (3) tick();
                check("after_reset_idle", 32'(outs()), 32'b000000);
                return;
            end
        end
        check("frame_bits", 32'(got), 32'(want));
        check("data_released_stop", 32'(bus.PS2_Data_Drive_Low_Out), 32'd0);

        if (mode == M_ACK) dev_data = 1'b0;
        repeat (2) tick();
        dev_clk = 1'b0;
        repeat (H) tick();
        dev_clk = 1'b1;
        if (mode == M_ACK) begin
            tick();
            dev_data = 1'b1;
        end

        n = 0;
        while (!bus.Tx_Done_Out && n < 200) begin
            tick();
            n++;
        end
        check("done_seen", 32'(bus.Tx_Done_Out), 32'd1);
        check("ack_err", 32'(bus.Tx_Ack_Error_Out), (mode == M_NOACK) ? 32'd1 : 32'd0);
        check("done_busy_drives", 32'({bus.PS2_Clk_Drive_Low_Out, bus.PS2_Data_Drive_Low_Out,
                                       bus.Tx_Busy_Out, bus.Rx_Inhibit_Out}), 32'b0000);
        if (chain) begin
            issue_start(d2);
            check("pulse_end_chain", 32'({bus.Tx_Done_Out, bus.Tx_Ack_Error_Out}), 32'b00);
        end else begin
            tick();
            check("pulse_end", 32'(outs()), 32'b000000);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] d2;
        bus.Tx_Data_In  = 8'h00;
        bus.Tx_Start_In = 1'b0;
        repeat (3) tick();
        check("reset_outs", 32'(outs()), 32'b000000);
        rst_n = 1'b1;
        repeat (10) tick();
        check("idle_outs", 32'(outs()), 32'b000000);

        issue_start(8'hED); do_frame(8'hED, M_ACK, 1'b0, 1'b0, 8'h00);
        issue_start(8'hFF); do_frame(8'hFF, M_ACK, 1'b0, 1'b0, 8'h00);
        issue_start(8'h02); do_frame(8'h02, M_ACK, 1'b0, 1'b0, 8'h00);
        issue_start(8'h00); do_frame(8'h00, M_ACK, 1'b0, 1'b0, 8'h00);

        d = 8'($urandom);
        issue_start(d); do_frame(d, M_NOACK, 1'b0, 1'b0, 8'h00);

        d = 8'($urandom);
        issue_start(d); do_frame(d, M_SILENT, 1'b0, 1'b0, 8'h00);

        // Start pulsed mid-frame is ignored; start on the done cycle is taken.
        d  = 8'($urandom);
        d2 = 8'($urandom);
        issue_start(d); do_frame(d, M_ACK, 1'b1, 1'b1, d2);
        do_frame(d2, M_ACK, 1'b0, 1'b0, 8'h00);

        d = 8'($urandom);
        issue_start(d); do_frame(d, M_RESET, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                issue_start(d); do_frame(d, M_ACK, 1'b0, 1'b0, 8'h00);
            end else begin
                issue_start(d); do_frame(d, M_NOACK, 1'b0, 1'b0, 8'h00);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
